reg32_write_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 32-bit storage register between four writers.
- Contains the 32-bit register and controls when it loads and from which requester.
- Grants bursts of up to MAX_HOLD consecutive writes per requester, with fair rotation between requesters.
- Sits between the four producer blocks and any consumer of the shared 32-bit value.

---
 rtl/reg32_write_arbiter.sv | 152 +++++++++++++++
 tb/tb_reg32_write_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg32_write_arbiter.sv
// Round-robin write arbiter for a shared 32-bit register.
// Four writers compete for the register. The winner gets a burst of up to
// MAX_HOLD consecutive writes. The rotation pointer then moves past it so the
// other writers get a fair turn. All outputs come straight from flops.
module reg32_write_arbiter #(
  parameter int          MAX_HOLD    = 4,
  parameter logic [31:0] RESET_VALUE = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] d0,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  input  logic [31:0] d3,
  output logic [3:0]  gnt,
  output logic [31:0] q,
  output logic        upd,
  output logic [1:0]  owner
);

  typedef enum logic {
    IDLE,
    GRANT
  } stateT;

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

  stateT       r_state;
  logic [1:0]  r_ptr;
  logic [3:0]  r_cnt;
  logic [1:0]  r_sel;
  logic [3:0]  r_gnt;
  logic [31:0] r_q;
  logic        r_upd;
  logic [1:0]  r_owner;

  stateT       w_nextState;
  logic [1:0]  w_nextPtr;
  logic [3:0]  w_nextCnt;
  logic [1:0]  w_nextSel;
  logic [3:0]  w_nextGnt;
  logic [31:0] w_nextQ;
  logic        w_nextUpd;
  logic [1:0]  w_nextOwner;

  logic [1:0]  w_pick;
  logic [1:0]  w_probe;
  logic [31:0] w_selData;
  logic [3:0]  w_cntInc;

  // Pick the first requester at or after the pointer. The scan runs from the
  // farthest offset to the nearest, so the nearest hit is the last one written.
  always_comb begin
    w_pick  = r_ptr;
    w_probe = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_probe = r_ptr + 2'(k);
      if (req[w_probe]) begin
        w_pick = w_probe;
      end
    end
  end

  // Route the data of the writer that currently holds the grant.
  always_comb begin
    case (r_sel)
      2'd0:    w_selData = d0;
      2'd1:    w_selData = d1;
      2'd2:    w_selData = d2;
      default: w_selData = d3;
    endcase
  end

  assign w_cntInc = r_cnt + 4'd1;

  // Next-state and next-output logic. The grant is issued one edge before the
  // first write. Both kinds of release (burst cap or dropped request) advance
  // the pointer past the released writer.
  always_comb begin
    w_nextState = r_state;
    w_nextPtr   = r_ptr;
    w_nextCnt   = r_cnt;
    w_nextSel   = r_sel;
    w_nextGnt   = r_gnt;
    w_nextQ     = r_q;
    w_nextUpd   = 1'b0;
    w_nextOwner = r_owner;
    case (r_state)
      IDLE: begin
        w_nextGnt = 4'b0000;
        if (req != 4'b0000) begin
          w_nextSel   = w_pick;
          w_nextGnt   = 4'b0001 << w_pick;
          w_nextCnt   = 4'd0;
          w_nextState = GRANT;
        end
      end
      GRANT: begin
        if (req[r_sel]) begin
          w_nextQ     = w_selData;
          w_nextUpd   = 1'b1;
          w_nextOwner = r_sel;
          w_nextCnt   = w_cntInc;
          if (w_cntInc == HOLD_LIMIT) begin
            w_nextGnt   = 4'b0000;
            w_nextPtr   = r_sel + 2'd1;
            w_nextState = IDLE;
          end
        end else begin
          w_nextGnt   = 4'b0000;
          w_nextPtr   = r_sel + 2'd1;
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextGnt   = 4'b0000;
        w_nextState = IDLE;
      end
    endcase
  end

  // State and output registers. Reset takes effect at once, so an active burst
  // is abandoned without a partial write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= 2'd0;
      r_cnt   <= 4'd0;
      r_sel   <= 2'd0;
      r_gnt   <= 4'b0000;
      r_q     <= RESET_VALUE;
      r_upd   <= 1'b0;
      r_owner <= 2'd0;
    end else begin
      r_state <= w_nextState;
      r_ptr   <= w_nextPtr;
      r_cnt   <= w_nextCnt;
      r_sel   <= w_nextSel;
      r_gnt   <= w_nextGnt;
      r_q     <= w_nextQ;
      r_upd   <= w_nextUpd;
      r_owner <= w_nextOwner;
    end
  end

  assign gnt   = r_gnt;
  assign q     = r_q;
  assign upd   = r_upd;
  assign owner = r_owner;

endmodule

// File: tb/tb_reg32_write_arbiter.sv
// Scoreboard bench for reg32_write_arbiter.
// A transaction-level model predicts, for each edge, the grant and the register
// contents, plus every write. A separate monitor pops those predictions and
// compares them with what the DUT shows.
module tb_reg32_write_arbiter;

  localparam int          MAX_HOLD    = 4;
  localparam logic [31:0] RESET_VALUE = 32'h00000000;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  who;
  } writeT;

  typedef struct {
    logic [3:0]  gnt;
    logic        upd;
    logic [31:0] q;
    logic [1:0]  owner;
  } cycleT;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] dArr [4];
  logic [3:0]  gnt;
  logic [31:0] q;
  logic        upd;
  logic [1:0]  owner;

  writeT writeQ [$];
  cycleT cycleQ [$];

  int checks = 0;
  int passes = 0;

  // Reference model: who holds the grant (-1 = nobody), how many writes it has
  // made so far, where the next search starts, and the last stored value.
  int          modelHolder = -1;
  int          modelWrites = 0;
  int          modelPtr    = 0;
  logic [31:0] modelQ      = RESET_VALUE;
  int          modelOwner  = 0;

  reg32_write_arbiter #(
    .MAX_HOLD   (MAX_HOLD),
    .RESET_VALUE(RESET_VALUE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .d0   (dArr[0]),
    .d1   (dArr[1]),
    .d2   (dArr[2]),
    .d3   (dArr[3]),
    .gnt  (gnt),
    .q    (q),
    .upd  (upd),
    .owner(owner)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %h, expected %h at time %0t", name, actual, expected, $time);
    end else begin
      passes++;
    end
  endtask

  // Predict what each edge does. The model works at the level of
  // "who holds the grant and how many writes it has made", and a reset
  // throws away any predictions the monitor has not yet used.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      modelHolder = -1;
      modelWrites = 0;
      modelPtr    = 0;
      modelQ      = RESET_VALUE;
      modelOwner  = 0;
      writeQ.delete();
      cycleQ.delete();
    end else begin
      cycleT c;
      c.upd = 1'b0;
      if (modelHolder < 0) begin
        if (req != 4'b0000) begin
          for (int k = 0; k < 4; k++) begin
            int cand;
            cand = (modelPtr + k) % 4;
            if (modelHolder < 0 && req[cand]) modelHolder = cand;
          end
          modelWrites = 0;
        end
      end else begin
        int released;
        released = modelHolder;
        if (req[modelHolder]) begin
          writeT w;
          modelQ      = dArr[modelHolder];
          modelOwner  = modelHolder;
          modelWrites = modelWrites + 1;
          c.upd       = 1'b1;
          w.data      = modelQ;
          w.who       = 2'(modelHolder);
          writeQ.push_back(w);
          if (modelWrites == MAX_HOLD) begin
            modelHolder = -1;
            modelPtr    = (released + 1) % 4;
          end
        end else begin
          modelHolder = -1;
          modelPtr    = (released + 1) % 4;
        end
      end
      c.gnt   = (modelHolder < 0) ? 4'b0000 : 4'(1 << modelHolder);
      c.q     = modelQ;
      c.owner = 2'(modelOwner);
      cycleQ.push_back(c);
    end
  end

  // Monitor: on every falling edge, compare the DUT with the oldest
  // prediction. Each write the DUT reports is matched against the write queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (cycleQ.size() > 0) begin
        cycleT c;
        c = cycleQ.pop_front();
        checkOutput("gnt", {28'd0, gnt}, {28'd0, c.gnt});
        checkOutput("upd", {31'd0, upd}, {31'd0, c.upd});
        checkOutput("q", q, c.q);
        checkOutput("owner", {30'd0, owner}, {30'd0, c.owner});
      end
      if (upd === 1'b1) begin
        if (writeQ.size() > 0) begin
          writeT w;
          w = writeQ.pop_front();
          checkOutput("write data", q, w.data);
          checkOutput("write owner", {30'd0, owner}, {30'd0, w.who});
        end else begin
          checkOutput("unexpected write", {31'd0, upd}, 32'd0);
        end
      end
    end
  end

  // Drive req for a number of cycles. Inputs change shortly after each rising
  // edge. The data words are refreshed at random unless fixed data is requested.
  task automatic applyStimulus(input logic [3:0] reqVal, input int cycles, input bit randData);
    repeat (cycles) begin
      @(posedge clk);
      #2;
      req = reqVal;
      if (randData) begin
        for (int i = 0; i < 4; i++) dArr[i] = $urandom;
      end
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " gnt"}, {28'd0, gnt}, 32'd0);
    checkOutput({tag, " q"}, q, RESET_VALUE);
    checkOutput({tag, " upd"}, {31'd0, upd}, 32'd0);
    checkOutput({tag, " owner"}, {30'd0, owner}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    for (int i = 0; i < 4; i++) dArr[i] = 32'h0;
    #1;
    checkResetOutputs("power-on reset");
    @(posedge clk);
    #2;
    reset = 1'b0;

    // One writer holds its request: a capped burst, one idle cycle, then a regrant.
    dArr[1] = 32'h12345678;
    applyStimulus(4'b0010, 10, 1'b0);

    // Early release: writer 2 makes two writes and then drops its request.
    applyStimulus(4'b0000, 2, 1'b1);
    dArr[2] = 32'hffeeddcc;
    applyStimulus(4'b0100, 3, 1'b0);
    applyStimulus(4'b0000, 3, 1'b1);

    // The pointer now sits at 3, so writer 3 wins over writer 0, then the pointer wraps.
    applyStimulus(4'b1001, 14, 1'b1);
    applyStimulus(4'b0000, 3, 1'b1);

    // Zero-write grant: a single-cycle pulse on req[0].
    applyStimulus(4'b0001, 1, 1'b1);
    applyStimulus(4'b0000, 4, 1'b1);

    // Full contention: the grant rotates through every writer.
    applyStimulus(4'b1111, 40, 1'b1);
    applyStimulus(4'b0000, 3, 1'b1);

    // Reset mid-burst: writer 1 makes two writes, then reset lands between edges.
    applyStimulus(4'b0010, 3, 1'b1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkResetOutputs("mid-burst reset");
    @(posedge clk);
    #2;
    reset = 1'b0;
    applyStimulus(4'b1111, 12, 1'b1);

    // Random traffic: each request pattern is held for a random span.
    for (int n = 0; n < 60; n++) begin
      applyStimulus(4'($urandom_range(0, 15)), $urandom_range(1, 8), 1'b1);
    end

    applyStimulus(4'b0000, 8, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("leftover writes", 32'(writeQ.size()), 32'd0);
    checkOutput("leftover cycles", 32'(cycleQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
